// File: rtl/trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl_pkg
// Description : Shared types and constants for the trap sequencing controller:
//               FSM state encoding, event kinds and interrupt cause codes.
// Revision    : 1.0 - initial release
// ============================================================================
package trap_ctrl_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_REDIRECT = 2'd2
  } trap_state_t;

  // Kind of event latched in IDLE
  typedef enum logic [1:0] {
    EV_EXC  = 2'd0,
    EV_INT  = 2'd1,
    EV_MRET = 2'd2,
    EV_SRET = 2'd3
  } trap_kind_t;

  // Interrupt cause codes (bit positions in mip/mie)
  localparam logic [4:0] IRQ_MEI = 5'd11;
  localparam logic [4:0] IRQ_MSI = 5'd3;
  localparam logic [4:0] IRQ_MTI = 5'd7;
  localparam logic [4:0] IRQ_SEI = 5'd9;
  localparam logic [4:0] IRQ_SSI = 5'd1;
  localparam logic [4:0] IRQ_STI = 5'd5;

endpackage : trap_ctrl_pkg
`default_nettype wire

// File: rtl/trap_ctrl_irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : irq_prio_enc
// Description : Combinational interrupt priority encoder.
//               Priority MEI > MSI > MTI > SEI > SSI > STI; other bits ignored.
// Ports       : i_pend  - pending & enabled interrupt vector (mip & mie)
//               o_hit   - at least one recognised interrupt is pending
//               o_code  - cause code of the winning interrupt (0 when no hit)
// Revision    : 1.0 - initial release
// ============================================================================
module irq_prio_enc
  import trap_ctrl_pkg::*;
(
  input  logic [31:0] i_pend,
  output logic        o_hit,
  output logic [4:0]  o_code
);

  // Bits outside the six recognised sources have no effect on the result
  logic w_unused_pend;
  assign w_unused_pend = ^{i_pend[31:12], i_pend[10], i_pend[8], i_pend[6],
                           i_pend[4], i_pend[2], i_pend[0]};

  always_comb begin
    o_hit  = 1'b1;
    o_code = 5'd0;
    if (i_pend[IRQ_MEI])      o_code = IRQ_MEI;
    else if (i_pend[IRQ_MSI]) o_code = IRQ_MSI;
    else if (i_pend[IRQ_MTI]) o_code = IRQ_MTI;
    else if (i_pend[IRQ_SEI]) o_code = IRQ_SEI;
    else if (i_pend[IRQ_SSI]) o_code = IRQ_SSI;
    else if (i_pend[IRQ_STI]) o_code = IRQ_STI;
    else                      o_hit  = 1'b0;
  end

endmodule : irq_prio_enc
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl
// Description : Trap sequencing controller between commit and the CSR file.
//               Arbitrates exception > interrupt > mret > sret, issues one
//               pulse per event, then flushes and performs a valid/ready
//               redirect handshake with fetch. All traps target M-mode.
// Ports       : i_exc_*         exception from the committing instruction
//               i_mret_req/sret commit of mret / sret
//               i_int_pc_valid  interrupt boundary available, i_int_pc its PC
//               i_mip/i_mie/i_mstatus_mie/i_priv_mode  interrupt eligibility
//               i_mtvec/i_mepc/i_sepc  CSR values for the redirect target
//               o_trap_enter + o_trap_cause/pc/val  trap pulse to CSR file
//               o_mret_exec/o_sret_exec  return pulses to CSR file
//               o_flush, o_busy  pipeline control
//               o_redirect_valid/o_redirect_pc, i_redirect_ready  fetch
// Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter bit VECTOR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_exc_valid,
  input  logic [4:0]  i_exc_code,
  input  logic [31:0] i_exc_pc,
  input  logic [31:0] i_exc_tval,
  input  logic        i_mret_req,
  input  logic        i_sret_req,
  input  logic        i_int_pc_valid,
  input  logic [31:0] i_int_pc,
  input  logic [31:0] i_mip,
  input  logic [31:0] i_mie,
  input  logic        i_mstatus_mie,
  input  logic [1:0]  i_priv_mode,
  input  logic [31:0] i_mtvec,
  input  logic [31:0] i_mepc,
  input  logic [31:0] i_sepc,
  output logic        o_trap_enter,
  output logic [31:0] o_trap_cause,
  output logic [31:0] o_trap_pc,
  output logic [31:0] o_trap_val,
  output logic        o_mret_exec,
  output logic        o_sret_exec,
  output logic        o_flush,
  output logic        o_busy,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc,
  input  logic        i_redirect_ready
);

  trap_state_t r_state;
  trap_kind_t  r_kind;
  logic        r_trap_enter;
  logic        r_mret_exec;
  logic        r_sret_exec;
  logic [31:0] r_trap_cause;
  logic [31:0] r_trap_pc;
  logic [31:0] r_trap_val;
  logic [31:0] r_redirect_pc;

  logic        w_irq_hit;
  logic [4:0]  w_irq_code;
  logic        w_int_take;
  logic        w_evt;
  trap_kind_t  w_kind;
  logic [31:0] w_cause;
  logic [31:0] w_pc;
  logic [31:0] w_val;
  logic [31:0] w_base;
  logic [31:0] w_target;

  irq_prio_enc u_irq_prio_enc (
    .i_pend (i_mip & i_mie),
    .o_hit  (w_irq_hit),
    .o_code (w_irq_code)
  );

  // Interrupts are globally enabled below M-mode regardless of mstatus.MIE
  assign w_int_take = w_irq_hit && i_int_pc_valid &&
                      ((i_priv_mode != 2'b11) || i_mstatus_mie);

  // Event arbitration: exception > interrupt > mret > sret
  always_comb begin
    w_evt   = 1'b1;
    w_kind  = EV_EXC;
    w_cause = {27'd0, i_exc_code};
    w_pc    = i_exc_pc;
    w_val   = i_exc_tval;
    if (i_exc_valid) begin
      w_kind = EV_EXC;
    end else if (w_int_take) begin
      w_kind  = EV_INT;
      w_cause = {1'b1, 26'd0, w_irq_code};
      w_pc    = i_int_pc;
      w_val   = 32'd0;
    end else if (i_mret_req) begin
      w_kind = EV_MRET;
    end else if (i_sret_req) begin
      w_kind = EV_SRET;
    end else begin
      w_evt = 1'b0;
    end
  end

  // Redirect target, evaluated during ISSUE from the latched event
  assign w_base = {i_mtvec[31:2], 2'b00};

  always_comb begin
    w_target = w_base;
    case (r_kind)
      EV_EXC:  w_target = w_base;
      EV_INT:  w_target = (VECTOR_EN && (i_mtvec[1:0] == 2'b01))
                          ? w_base + {25'd0, r_trap_cause[4:0], 2'b00}
                          : w_base;
      EV_MRET: w_target = i_mepc;
      EV_SRET: w_target = i_sepc;
      default: w_target = w_base;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_kind        <= EV_EXC;
      r_trap_enter  <= 1'b0;
      r_mret_exec   <= 1'b0;
      r_sret_exec   <= 1'b0;
      r_trap_cause  <= 32'd0;
      r_trap_pc     <= 32'd0;
      r_trap_val    <= 32'd0;
      r_redirect_pc <= 32'd0;
    end else begin
      r_trap_enter <= 1'b0;
      r_mret_exec  <= 1'b0;
      r_sret_exec  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_evt) begin
            r_state      <= ST_ISSUE;
            r_kind       <= w_kind;
            r_trap_cause <= w_cause;
            r_trap_pc    <= w_pc;
            r_trap_val   <= w_val;
            // Pulses are registered so they appear in the ISSUE cycle
            r_trap_enter <= (w_kind == EV_EXC) || (w_kind == EV_INT);
            r_mret_exec  <= (w_kind == EV_MRET);
            r_sret_exec  <= (w_kind == EV_SRET);
          end
        end
        ST_ISSUE: begin
          r_redirect_pc <= w_target;
          r_state       <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          if (i_redirect_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_trap_enter     = r_trap_enter;
  assign o_trap_cause     = r_trap_cause;
  assign o_trap_pc        = r_trap_pc;
  assign o_trap_val       = r_trap_val;
  assign o_mret_exec      = r_mret_exec;
  assign o_sret_exec      = r_sret_exec;
  assign o_busy           = (r_state != ST_IDLE);
  assign o_flush          = (r_state != ST_IDLE);
  assign o_redirect_valid = (r_state == ST_REDIRECT);
  assign o_redirect_pc    = r_redirect_pc;

endmodule : trap_ctrl
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_trap_ctrl
// Description : Self-checking bench for trap_ctrl. Two instances share all
//               inputs: one with vectored mode honoured, one forced direct.
//               A transaction-level model predicts pulses, flush and the
//               redirect target; directed cases pin literal values, then a
//               randomized phase exercises arbitration and handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        exc_valid, mret_req, sret_req, int_pc_valid, mstatus_mie;
  logic        redirect_ready;
  logic [4:0]  exc_code;
  logic [1:0]  priv_mode;
  logic [31:0] exc_pc, exc_tval, int_pc, mip, mie, mtvec, mepc, sepc;

  logic        trap_enter, mret_exec, sret_exec, flush, busy, redirect_valid;
  logic [31:0] trap_cause, trap_pc, trap_val, redirect_pc;
  logic        nv_trap_enter, nv_mret_exec, nv_sret_exec, nv_flush, nv_busy;
  logic        nv_redirect_valid;
  logic [31:0] nv_trap_cause, nv_trap_pc, nv_trap_val, nv_redirect_pc;

  trap_ctrl #(.VECTOR_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_exc_valid(exc_valid), .i_exc_code(exc_code), .i_exc_pc(exc_pc),
    .i_exc_tval(exc_tval), .i_mret_req(mret_req), .i_sret_req(sret_req),
    .i_int_pc_valid(int_pc_valid), .i_int_pc(int_pc), .i_mip(mip), .i_mie(mie),
    .i_mstatus_mie(mstatus_mie), .i_priv_mode(priv_mode), .i_mtvec(mtvec),
    .i_mepc(mepc), .i_sepc(sepc),
    .o_trap_enter(trap_enter), .o_trap_cause(trap_cause), .o_trap_pc(trap_pc),
    .o_trap_val(trap_val), .o_mret_exec(mret_exec), .o_sret_exec(sret_exec),
    .o_flush(flush), .o_busy(busy), .o_redirect_valid(redirect_valid),
    .o_redirect_pc(redirect_pc), .i_redirect_ready(redirect_ready)
  );

  trap_ctrl #(.VECTOR_EN(1'b0)) u_dut_nv (
    .clk(clk), .rst_n(rst_n),
    .i_exc_valid(exc_valid), .i_exc_code(exc_code), .i_exc_pc(exc_pc),
    .i_exc_tval(exc_tval), .i_mret_req(mret_req), .i_sret_req(sret_req),
    .i_int_pc_valid(int_pc_valid), .i_int_pc(int_pc), .i_mip(mip), .i_mie(mie),
    .i_mstatus_mie(mstatus_mie), .i_priv_mode(priv_mode), .i_mtvec(mtvec),
    .i_mepc(mepc), .i_sepc(sepc),
    .o_trap_enter(nv_trap_enter), .o_trap_cause(nv_trap_cause),
    .o_trap_pc(nv_trap_pc), .o_trap_val(nv_trap_val),
    .o_mret_exec(nv_mret_exec), .o_sret_exec(nv_sret_exec),
    .o_flush(nv_flush), .o_busy(nv_busy), .o_redirect_valid(nv_redirect_valid),
    .o_redirect_pc(nv_redirect_pc), .i_redirect_ready(redirect_ready)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: one outstanding event, sampled at cycle m_evt
  bit          m_active = 1'b0;
  int          m_evt    = 0;
  int          m_kind   = 0;   // 0 exc, 1 int, 2 mret, 3 sret
  logic [31:0] m_cause, m_pc, m_val, m_tgt, m_tgt_nv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic clr_events();
    exc_valid = 1'b0; mret_req = 1'b0; sret_req = 1'b0;
    int_pc_valid = 1'b0; mip = 32'd0; mie = 32'd0;
  endtask

  // Decide what the inputs of the current cycle cause at the next edge
  task automatic model_step();
    int          prio [6] = '{11, 3, 7, 9, 1, 5};
    logic [31:0] pend, base;
    bit          hit;
    int          code;
    if (m_active) begin
      if (cyc >= m_evt + 2 && redirect_ready) m_active = 1'b0;
    end else begin
      pend = mip & mie;
      hit  = 1'b0;
      code = 0;
      if (int_pc_valid && (priv_mode != 2'b11 || mstatus_mie))
        for (int i = 0; i < 6; i++)
          if (!hit && pend[prio[i]]) begin hit = 1'b1; code = prio[i]; end
      base = mtvec & 32'hFFFF_FFFC;
      if (exc_valid) begin
        m_kind = 0; m_cause = {27'd0, exc_code}; m_pc = exc_pc; m_val = exc_tval;
        m_tgt = base; m_tgt_nv = base; m_active = 1'b1;
      end else if (hit) begin
        m_kind = 1; m_cause = 32'h8000_0000 | 32'(code); m_pc = int_pc; m_val = 32'd0;
        m_tgt = (mtvec[1:0] == 2'b01) ? base + 32'(code * 4) : base;
        m_tgt_nv = base; m_active = 1'b1;
      end else if (mret_req) begin
        m_kind = 2; m_tgt = mepc; m_tgt_nv = mepc; m_active = 1'b1;
      end else if (sret_req) begin
        m_kind = 3; m_tgt = sepc; m_tgt_nv = sepc; m_active = 1'b1;
      end
      if (m_active) m_evt = cyc;
    end
  endtask

  // Per-cycle comparison of both instances against the model
  task automatic compare();
    bit issue, redir, fl;
    issue = m_active && (cyc == m_evt + 1);
    redir = m_active && (cyc >= m_evt + 2);
    fl    = m_active && (cyc >= m_evt + 1);
    chk("busy", busy, fl);
    chk("flush", flush, fl);
    chk("trap_enter", trap_enter, issue && m_kind <= 1);
    chk("mret_exec", mret_exec, issue && m_kind == 2);
    chk("sret_exec", sret_exec, issue && m_kind == 3);
    chk("redirect_valid", redirect_valid, redir);
    chk("nv_redirect_valid", nv_redirect_valid, redir);
    chk("nv_trap_enter", nv_trap_enter, issue && m_kind <= 1);
    if (issue && m_kind <= 1) begin
      chk("trap_cause", trap_cause, m_cause);
      chk("trap_pc", trap_pc, m_pc);
      chk("trap_val", trap_val, m_val);
    end
    if (redir) begin
      chk("redirect_pc", redirect_pc, m_tgt);
      chk("nv_redirect_pc", nv_redirect_pc, m_tgt_nv);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    compare();
  endtask

  task automatic finish_redirect();
    clr_events();
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    chk("idle_after_handshake", busy, 1'b0);
  endtask

  initial begin
    clr_events();
    exc_code = 5'd0; exc_pc = 32'd0; exc_tval = 32'd0; int_pc = 32'd0;
    mstatus_mie = 1'b0; priv_mode = 2'b11; redirect_ready = 1'b0;
    mtvec = 32'd0; mepc = 32'd0; sepc = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    compare();
    chk("reset_cause", trap_cause, 32'd0);
    chk("reset_rpc", redirect_pc, 32'd0);

    // Synchronous exception
    exc_valid = 1'b1; exc_code = 5'd2; exc_pc = 32'h8000_0010;
    exc_tval = 32'h0000_DEAD; mtvec = 32'h8000_0100;
    tick();
    chk("exc_enter", trap_enter, 1'b1);
    chk("exc_cause", trap_cause, 32'h2);
    chk("exc_pc", trap_pc, 32'h8000_0010);
    chk("exc_val", trap_val, 32'h0000_DEAD);
    clr_events();
    tick();
    chk("exc_rpc", redirect_pc, 32'h8000_0100);
    finish_redirect();

    // Vectored timer interrupt
    mip = 32'h80; mie = 32'h80; mstatus_mie = 1'b1; priv_mode = 2'b11;
    int_pc_valid = 1'b1; int_pc = 32'h44; mtvec = 32'h8000_0101;
    tick();
    chk("mti_cause", trap_cause, 32'h8000_0007);
    chk("mti_pc", trap_pc, 32'h44);
    clr_events();
    tick();
    chk("mti_rpc_vec", redirect_pc, 32'h8000_011C);
    chk("mti_rpc_direct", nv_redirect_pc, 32'h8000_0100);
    finish_redirect();

    // MEI beats MTI
    mip = 32'h880; mie = 32'h880; int_pc_valid = 1'b1;
    tick();
    chk("mei_cause", trap_cause, 32'h8000_000B);
    clr_events();
    tick();
    finish_redirect();

    // Globally disabled in M-mode, enabled in U-mode
    mip = 32'h80; mie = 32'h80; int_pc_valid = 1'b1; mstatus_mie = 1'b0;
    tick();
    chk("mie0_no_trap", busy, 1'b0);
    priv_mode = 2'b00;
    tick();
    chk("umode_trap", trap_enter, 1'b1);
    chk("umode_cause", trap_cause, 32'h8000_0007);
    clr_events();
    tick();
    finish_redirect();

    // Exception wins over mret
    exc_valid = 1'b1; mret_req = 1'b1; exc_code = 5'd4;
    tick();
    chk("excmret_enter", trap_enter, 1'b1);
    chk("excmret_mret", mret_exec, 1'b0);
    clr_events();
    tick();
    finish_redirect();

    // mret alone, then stalled redirect with ignored exception
    mret_req = 1'b1; mepc = 32'h200;
    tick();
    chk("mret_pulse", mret_exec, 1'b1);
    clr_events();
    tick();
    chk("mret_rpc", redirect_pc, 32'h200);
    exc_valid = 1'b1;
    repeat (5) tick();
    chk("stall_valid", redirect_valid, 1'b1);
    chk("stall_rpc", redirect_pc, 32'h200);
    chk("stall_flush", flush, 1'b1);
    finish_redirect();

    // Reset during REDIRECT
    exc_valid = 1'b1; exc_code = 5'd7;
    tick();
    clr_events();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", redirect_valid, 1'b0);
    chk("rst_flush", flush, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rpc", redirect_pc, 32'd0);
    chk("rst_cause", trap_cause, 32'd0);
    m_active = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();

    // Randomized phase
    for (int n = 0; n < 4000; n++) begin
      exc_valid    = ($urandom_range(0, 7) == 0);
      exc_code     = 5'($urandom);
      exc_pc       = $urandom;
      exc_tval     = $urandom;
      mret_req     = ($urandom_range(0, 5) == 0);
      sret_req     = ($urandom_range(0, 5) == 0);
      int_pc_valid = $urandom_range(0, 1) == 1;
      int_pc       = $urandom;
      mip          = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'h0000_0AAA);
      mie          = ($urandom_range(0, 2) == 0) ? $urandom : 32'd0;
      mstatus_mie  = $urandom_range(0, 1) == 1;
      priv_mode    = 2'($urandom);
      redirect_ready = $urandom_range(0, 1) == 1;
      if (!m_active) begin
        mtvec = $urandom;
        if ($urandom_range(0, 1) == 1) mtvec[1:0] = 2'b01;
        mepc = $urandom;
        sepc = $urandom;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_trap_ctrl
`default_nettype wire
